ro_event_capture: RTL and testbench

- Sits directly downstream of the 8-channel readout array.
- Samples the shared serial outputs out_mux_pol and out_mux_pol_eve on the global readout clock.
- Decodes which channel owns each clock slot from the gray-counter step sequence, and tags every active sample with channel and timestamp.
- Buffers tagged events in a small FIFO with a valid/ready handshake toward the host/packetizer, and flags overflow and gray-counter desync.

---
 rtl/ro_event_capture_pkg.sv | 50 +++++
 rtl/ro_event_capture_fifo.sv | 77 +++++++
 rtl/ro_event_capture.sv | 122 ++++++++++++
 tb/tb_ro_event_capture.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_event_capture_pkg.sv
// -----------------------------------------------------------------------------
// ro_pkg
// Shared definitions for the readout event-capture block.
//   - default channel count, timestamp width and channel-index width
//   - bit offsets of the fields inside an event word
//   - slot classification type
//   - bin2gray and trailing-ones helper functions
// -----------------------------------------------------------------------------
package ro_pkg;

    localparam int unsigned N_CH_DEFAULT = 8;
    localparam int unsigned TS_W_DEFAULT = 17;
    localparam int unsigned CH_W_DEFAULT = 3;

    // Event word layout: {ts, ch, pol, eve}, eve at bit 0.
    localparam int unsigned EV_EVE    = 0;
    localparam int unsigned EV_POL    = 1;
    localparam int unsigned EV_CH_LSB = 2;
    localparam int unsigned EV_TS_LSB = CH_W_DEFAULT + 2;

    // A clock slot either belongs to one channel or is the idle slot that
    // occurs when all low counter bits are ones.
    typedef enum logic {
        SLOT_CHANNEL = 1'b0,
        SLOT_IDLE    = 1'b1
    } slot_kind_e;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Number of consecutive ones starting at bit 0, looking at the lowest
    // n bits only; result ranges 0..n.
    function automatic int unsigned trailing_ones(input logic [31:0] v,
                                                  input int unsigned n);
        int unsigned count;
        logic        run;
        count = 0;
        run   = 1'b1;
        for (int unsigned i = 0; i < 32; i++) begin
            if (run && (i < n) && v[i]) begin
                count = count + 1;
            end else begin
                run = 1'b0;
            end
        end
        return count;
    endfunction

endpackage

// File: rtl/ro_event_capture_fifo.sv
// -----------------------------------------------------------------------------
// ro_event_fifo
// First-word fall-through synchronous FIFO with asynchronous active-low reset.
// A push while full is still accepted when a pop happens on the same edge.
//
// Ports:
//   clk        clock
//   rstb       asynchronous active-low reset, empties the FIFO
//   push       write request
//   push_data  write word
//   pop        consumer ready; ignored while empty
//   valid      head word present
//   data       head word (zero while empty)
//   full       FIFO holds DEPTH words
//   level      current occupancy
// -----------------------------------------------------------------------------
module ro_event_fifo #(
    parameter  int unsigned W     = 22,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic          valid,
    output logic [W-1:0]  data,
    output logic          full,
    output logic [AW:0]   level
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          empty;
    logic          do_pop;
    logic          do_push;

    always_comb begin
        empty   = (level == '0);
        full    = (level == (AW+1)'(DEPTH));
        do_pop  = pop & ~empty;
        // Freeing a slot on this edge lets a push into a full FIFO through.
        do_push = push & (~full | do_pop);
        valid   = ~empty;
        data    = empty ? '0 : mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: a word is only observable after being written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ro_event_capture.sv
// -----------------------------------------------------------------------------
// ro_event_capture
// Samples the shared serial outputs of the 8-channel readout array, decodes
// the owning channel of each clock slot from the gray-counter step sequence,
// tags active samples with channel and timestamp and buffers them in a FIFO.
//
// Ports:
//   clk          global readout clock (same as the gray counter)
//   rstb         asynchronous active-low reset
//   en           count/sample enable (tied to the gray counter enable)
//   gray         gray counter value, checked against the local slot counter
//   mux_pol      serial polarity bit
//   mux_pol_eve  serial even-polarity bit
//   ev_valid     FIFO head valid
//   ev_ready     consumer accepts the head
//   ev_data      {ts, ch, pol, eve}
//   fifo_level   current FIFO occupancy
//   ovf          sticky overflow flag
//   drop_cnt     saturating count of dropped events
//   sync_err     sticky gray mismatch flag
//   err_clr      synchronous clear of ovf, drop_cnt and sync_err
// -----------------------------------------------------------------------------
module ro_event_capture
    import ro_pkg::*;
#(
    parameter int unsigned N_CH       = N_CH_DEFAULT,
    parameter int unsigned TS_W       = TS_W_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CH_W       = CH_W_DEFAULT,
    parameter int unsigned EV_W       = TS_W + CH_W + 2
) (
    input  logic                        clk,
    input  logic                        rstb,
    input  logic                        en,
    input  logic [TS_W-1:0]             gray,
    input  logic                        mux_pol,
    input  logic                        mux_pol_eve,
    output logic                        ev_valid,
    input  logic                        ev_ready,
    output logic [EV_W-1:0]             ev_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        ovf,
    output logic [7:0]                  drop_cnt,
    output logic                        sync_err,
    input  logic                        err_clr
);

    localparam int unsigned TS_LSB = EV_CH_LSB + CH_W;

    logic [TS_W-1:0] cnt;
    int unsigned     t;
    slot_kind_e      slot;
    logic [CH_W-1:0] ch;
    logic            push;
    logic [EV_W-1:0] push_data;
    logic            full;
    logic            drop;
    logic [TS_W-1:0] gray_exp;
    logic            mismatch;

    // Slot decode: the gray bit flipping at this step is the number of
    // trailing ones of the low counter bits; all-ones is the idle slot.
    always_comb begin
        t        = trailing_ones(32'(cnt[N_CH-1:0]), N_CH);
        slot     = (t < N_CH) ? SLOT_CHANNEL : SLOT_IDLE;
        ch       = t[CH_W-1:0];
        push     = en & (slot == SLOT_CHANNEL) & (mux_pol | mux_pol_eve);

        push_data                      = '0;
        push_data[TS_LSB +: TS_W]      = cnt;
        push_data[EV_CH_LSB +: CH_W]   = ch;
        push_data[EV_POL]              = mux_pol;
        push_data[EV_EVE]              = mux_pol_eve;

        // Full implies a valid head, so a ready consumer always frees a slot.
        drop     = push & full & ~ev_ready;

        gray_exp = TS_W'(bin2gray(32'(cnt)));
        mismatch = en & (gray != gray_exp);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TS_W'(1);
        end
    end

    // Error flags: a new error on the clearing edge takes precedence.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
            sync_err <= 1'b0;
        end else begin
            ovf      <= drop | (ovf & ~err_clr);
            sync_err <= mismatch | (sync_err & ~err_clr);
            if (err_clr) begin
                drop_cnt <= 8'(drop);
            end else if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    ro_event_fifo #(
        .W     (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstb      (rstb),
        .push      (push),
        .push_data (push_data),
        .pop       (ev_ready),
        .valid     (ev_valid),
        .data      (ev_data),
        .full      (full),
        .level     (fifo_level)
    );

endmodule

// File: tb/tb_ro_event_capture.sv
// -----------------------------------------------------------------------------
// tb_ro_event_capture
// Self-checking bench for ro_event_capture. A queue-based reference model
// tracks the slot counter, expected FIFO contents and error flags from the
// behavioural rules; each scenario task compares DUT outputs at the falling
// edge.
// -----------------------------------------------------------------------------
module tb_ro_event_capture;

    logic        clk = 1'b0;
    logic        rstb;
    logic        en;
    logic [16:0] gray;
    logic        mux_pol;
    logic        mux_pol_eve;
    logic        ev_valid;
    logic        ev_ready;
    logic [21:0] ev_data;
    logic [3:0]  fifo_level;
    logic        ovf;
    logic [7:0]  drop_cnt;
    logic        sync_err;
    logic        err_clr;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_cnt;
    logic [21:0] m_q[$];
    bit          m_ovf;
    int          m_drop;
    bit          m_sync;
    logic [16:0] gray_corrupt;

    int ch_seq[8] = '{0, 1, 0, 2, 0, 1, 0, 3};

    always #5 clk = ~clk;

    ro_event_capture dut (
        .clk         (clk),
        .rstb        (rstb),
        .en          (en),
        .gray        (gray),
        .mux_pol     (mux_pol),
        .mux_pol_eve (mux_pol_eve),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_data     (ev_data),
        .fifo_level  (fifo_level),
        .ovf         (ovf),
        .drop_cnt    (drop_cnt),
        .sync_err    (sync_err),
        .err_clr     (err_clr)
    );

    function automatic logic [21:0] mk_ev(int ts, int ch, bit pol, bit eve);
        return 22'(ts * 32 + ch * 4 + int'(pol) * 2 + int'(eve));
    endfunction

    function automatic logic [21:0] head_exp();
        return (m_q.size() > 0) ? m_q[0] : 22'h0;
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_q.delete();
        m_ovf  = 0;
        m_drop = 0;
        m_sync = 0;
    endtask

    // Called at a falling edge with inputs set; advances model and DUT by one edge.
    task automatic cycle();
        bit pop, drop, mis;
        int low, p, ch;
        gray = 17'(m_cnt ^ (m_cnt >> 1)) ^ gray_corrupt;
        pop  = (m_q.size() > 0) && ev_ready;
        drop = 0;
        mis  = 0;
        if (pop) void'(m_q.pop_front());
        if (en) begin
            low = m_cnt % 256;
            if (low != 255 && (mux_pol || mux_pol_eve)) begin
                p  = (low + 1) & ~low;
                ch = 0;
                while (p > 1) begin p = p >> 1; ch++; end
                if (m_q.size() < 8) m_q.push_back(mk_ev(m_cnt, ch, mux_pol, mux_pol_eve));
                else drop = 1;
            end
            mis   = (gray != 17'(m_cnt ^ (m_cnt >> 1)));
            m_cnt = (m_cnt + 1) % 131072;
        end
        m_ovf  = drop || (m_ovf && !err_clr);
        m_sync = mis || (m_sync && !err_clr);
        if (err_clr) m_drop = drop ? 1 : 0;
        else if (drop && m_drop < 255) m_drop = m_drop + 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        en = 0; mux_pol = 0; mux_pol_eve = 0; ev_ready = 0; err_clr = 0;
        gray_corrupt = '0; gray = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rstb = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (ev_valid !== 1'b0)    begin errors++; $display("FAIL reset_valid got %b exp 0", ev_valid); end
        if (ev_data !== 22'h0)    begin errors++; $display("FAIL reset_data got %h exp 0", ev_data); end
        if (fifo_level !== 4'd0)  begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
        if (ovf !== 1'b0)         begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
        if (drop_cnt !== 8'd0)    begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_cnt); end
        if (sync_err !== 1'b0)    begin errors++; $display("FAIL reset_sync got %b exp 0", sync_err); end
    endtask

    task automatic test_slot_sequence();
        do_reset();
        en = 1; mux_pol = 1; ev_ready = 1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            checks += 3;
            if (ev_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %b exp 1", i, ev_valid); end
            if (ev_data !== mk_ev(i, ch_seq[i], 1, 0)) begin errors++; $display("FAIL seq_data[%0d] got %h exp %h", i, ev_data, mk_ev(i, ch_seq[i], 1, 0)); end
            if (ev_data !== head_exp()) begin errors++; $display("FAIL seq_model[%0d] got %h exp %h", i, ev_data, head_exp()); end
        end
    endtask

    task automatic test_idle_slot();
        do_reset();
        en = 1; mux_pol = 0; ev_ready = 1;
        repeat (254) cycle();
        mux_pol = 1;
        cycle();
        checks += 3;
        if (ev_data !== mk_ev(254, 0, 1, 0)) begin errors++; $display("FAIL idle_ts254 got %h exp %h", ev_data, mk_ev(254, 0, 1, 0)); end
        cycle();
        if (ev_valid !== 1'b0) begin errors++; $display("FAIL idle_ts255 valid got %b exp 0", ev_valid); end
        cycle();
        if (ev_data !== mk_ev(256, 0, 1, 0)) begin errors++; $display("FAIL idle_ts256 got %h exp %h", ev_data, mk_ev(256, 0, 1, 0)); end
    endtask

    task automatic test_overflow();
        do_reset();
        en = 1; mux_pol = 1; ev_ready = 0;
        repeat (10) cycle();
        checks += 3;
        if (fifo_level !== 4'd8) begin errors++; $display("FAIL ovf_level got %0d exp 8", fifo_level); end
        if (ovf !== 1'b1)        begin errors++; $display("FAIL ovf_flag got %b exp 1", ovf); end
        if (drop_cnt !== 8'd2)   begin errors++; $display("FAIL ovf_drop got %0d exp 2", drop_cnt); end
        en = 0; mux_pol = 0; ev_ready = 1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (ev_data !== mk_ev(i, ch_seq[i], 1, 0)) begin errors++; $display("FAIL drain[%0d] got %h exp %h", i, ev_data, mk_ev(i, ch_seq[i], 1, 0)); end
            cycle();
        end
        checks++;
        if (ev_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", ev_valid); end
        err_clr = 1;
        cycle();
        err_clr = 0;
        checks += 2;
        if (ovf !== 1'b0)      begin errors++; $display("FAIL clr_ovf got %b exp 0", ovf); end
        if (drop_cnt !== 8'd0) begin errors++; $display("FAIL clr_drop got %0d exp 0", drop_cnt); end
    endtask

    task automatic test_full_stream();
        do_reset();
        en = 1; mux_pol = 1; ev_ready = 0;
        repeat (8) cycle();
        ev_ready = 1;
        for (int j = 0; j < 12; j++) begin
            cycle();
            checks += 4;
            if (fifo_level !== 4'd8) begin errors++; $display("FAIL full_level[%0d] got %0d exp 8", j, fifo_level); end
            if (drop_cnt !== 8'd0)   begin errors++; $display("FAIL full_drop[%0d] got %0d exp 0", j, drop_cnt); end
            if (ev_data !== head_exp()) begin errors++; $display("FAIL full_data[%0d] got %h exp %h", j, ev_data, head_exp()); end
            if (ev_data[21:5] !== 17'(j + 1)) begin errors++; $display("FAIL full_order[%0d] got %0d exp %0d", j, ev_data[21:5], j + 1); end
        end
    endtask

    task automatic test_sync();
        do_reset();
        en = 1; mux_pol = 0; ev_ready = 1;
        repeat (4) cycle();
        checks++;
        if (sync_err !== 1'b0) begin errors++; $display("FAIL sync_clean got %b exp 0", sync_err); end
        gray_corrupt = 17'h8;
        cycle();
        gray_corrupt = '0;
        checks++;
        if (sync_err !== 1'b1) begin errors++; $display("FAIL sync_set got %b exp 1", sync_err); end
        repeat (3) cycle();
        checks++;
        if (sync_err !== 1'b1) begin errors++; $display("FAIL sync_sticky got %b exp 1", sync_err); end
        err_clr = 1;
        cycle();
        err_clr = 0;
        checks++;
        if (sync_err !== 1'b0) begin errors++; $display("FAIL sync_clr got %b exp 0", sync_err); end
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 1; mux_pol = 1; ev_ready = 0;
        repeat (5) cycle();
        checks++;
        if (fifo_level !== 4'd5) begin errors++; $display("FAIL arst_pre_level got %0d exp 5", fifo_level); end
        #2 rstb = 1'b0;
        #1;
        checks += 2;
        if (ev_valid !== 1'b0)   begin errors++; $display("FAIL arst_valid got %b exp 0", ev_valid); end
        if (fifo_level !== 4'd0) begin errors++; $display("FAIL arst_level got %0d exp 0", fifo_level); end
        model_reset();
        @(negedge clk);
        rstb = 1'b1; en = 1; mux_pol = 1; ev_ready = 1;
        cycle();
        checks += 2;
        if (ev_valid !== 1'b1) begin errors++; $display("FAIL arst_first_valid got %b exp 1", ev_valid); end
        if (ev_data !== mk_ev(0, 0, 1, 0)) begin errors++; $display("FAIL arst_first_data got %h exp %h", ev_data, mk_ev(0, 0, 1, 0)); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            en           = ($urandom_range(3, 0) != 0);
            mux_pol      = $urandom_range(1, 0) == 1;
            mux_pol_eve  = $urandom_range(2, 0) == 0;
            ev_ready     = $urandom_range(2, 0) == 0;
            err_clr      = $urandom_range(30, 0) == 0;
            gray_corrupt = ($urandom_range(40, 0) == 0) ? 17'(1 << $urandom_range(16, 0)) : 17'h0;
            cycle();
            checks += 6;
            if (ev_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %b exp %b", i, ev_valid, m_q.size() > 0); end
            if (ev_data !== head_exp())        begin errors++; $display("FAIL rnd_data[%0d] got %h exp %h", i, ev_data, head_exp()); end
            if (fifo_level !== 4'(m_q.size())) begin errors++; $display("FAIL rnd_level[%0d] got %0d exp %0d", i, fifo_level, m_q.size()); end
            if (ovf !== m_ovf)                 begin errors++; $display("FAIL rnd_ovf[%0d] got %b exp %b", i, ovf, m_ovf); end
            if (drop_cnt !== 8'(m_drop))       begin errors++; $display("FAIL rnd_drop[%0d] got %0d exp %0d", i, drop_cnt, m_drop); end
            if (sync_err !== m_sync)           begin errors++; $display("FAIL rnd_sync[%0d] got %b exp %b", i, sync_err, m_sync); end
        end
        gray_corrupt = '0;
        err_clr = 0;
    endtask

    initial begin
        rstb = 1'b0;
        en = 0; mux_pol = 0; mux_pol_eve = 0; ev_ready = 0; err_clr = 0;
        gray = '0; gray_corrupt = '0;
        @(negedge clk);
        test_reset();
        test_slot_sequence();
        test_idle_slot();
        test_overflow();
        test_full_stream();
        test_sync();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
